// File: rtl/board_draw_scheduler_pkg.sv
// board_draw_scheduler_pkg: shared Othello cell encodings, board sizes and scheduler FSM types
package board_draw_scheduler_pkg;
    localparam logic [1:0] CELL_EMPTY  = 2'd0;
    localparam logic [1:0] CELL_BLACK  = 2'd1;
    localparam logic [1:0] CELL_WHITE  = 2'd2;
    localparam logic [1:0] CELL_HILITE = 2'd3;
    localparam int BOARD_DIM = 8;
    localparam int NUM_CELLS = BOARD_DIM * BOARD_DIM;
    typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_NEXT, ST_FIN} state_t;
    typedef enum logic {MODE_FULL, MODE_CELL} mode_t;
endpackage

// File: rtl/board_cell_coord.sv
// board_cell_coord: maps a cell index to the top-left pixel of that cell
//   idx [5:0] in  : cell index, [5:3]=row, [2:0]=col
//   x   [7:0] out : ORIGIN_X + PITCH*col
//   y   [6:0] out : ORIGIN_Y + PITCH*row (7-bit result, max 100)
module board_cell_coord #(
    parameter int ORIGIN_X = 9,
    parameter int ORIGIN_Y = 9,
    parameter int PITCH    = 13
) (
    input  logic [5:0] idx,
    output logic [7:0] x,
    output logic [6:0] y
);
    assign x = 8'(ORIGIN_X) + 8'(PITCH) * {5'd0, idx[2:0]};
    assign y = 7'(ORIGIN_Y) + 7'(PITCH) * {4'd0, idx[5:3]};
endmodule

// File: rtl/board_draw_scheduler.sv
// board_draw_scheduler: sequences the cell-plot engine for full-board redraws and single-cell updates
//   clock, resetn            : clock, asynchronous active-low reset
//   board[127:0]             : cell states, cell i at board[2i+1:2i]
//   redraw_req               : pulse, request a full 64-cell pass
//   cell_req, cell_idx[5:0]  : single-cell request, accepted while cell_ready=1
//   cell_ready               : no single-cell request pending
//   plot_start/x/y/select    : engine command, coords and state held until plot_done
//   plot_done                : engine finished current cell
//   busy, redraw_done, cell_done : status and completion pulses
module board_draw_scheduler
    import board_draw_scheduler_pkg::*;
#(
    parameter int ORIGIN_X = 9,
    parameter int ORIGIN_Y = 9,
    parameter int PITCH    = 13
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic [127:0] board,
    input  logic         redraw_req,
    input  logic         cell_req,
    input  logic [5:0]   cell_idx,
    output logic         cell_ready,
    output logic         plot_start,
    output logic [7:0]   plot_x,
    output logic [6:0]   plot_y,
    output logic [1:0]   plot_select,
    input  logic         plot_done,
    output logic         busy,
    output logic         redraw_done,
    output logic         cell_done
);
    state_t      state_q, state_d;
    mode_t       mode_q, mode_d;
    logic [5:0]  idx_q, idx_d;
    logic [5:0]  cell_idx_q, cell_idx_d;
    logic        redraw_pend_q, redraw_pend_d;
    logic        cell_pend_q, cell_pend_d;
    logic        plot_start_q, plot_start_d;
    logic [7:0]  plot_x_q, plot_x_d;
    logic [6:0]  plot_y_q, plot_y_d;
    logic [1:0]  plot_select_q, plot_select_d;
    logic        busy_q, busy_d;
    logic        redraw_done_q, redraw_done_d;
    logic        cell_done_q, cell_done_d;
    logic        take_redraw, issue, fin_full, fin_cell, cell_accept;
    logic [7:0]  cell_x;
    logic [6:0]  cell_y;

    // Coordinates are computed for the index being entered, so they are registered on entry to ISSUE
    board_cell_coord #(.ORIGIN_X(ORIGIN_X), .ORIGIN_Y(ORIGIN_Y), .PITCH(PITCH)) u_coord (
        .idx (idx_d),
        .x   (cell_x),
        .y   (cell_y)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        idx_d       = idx_q;
        take_redraw = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (redraw_pend_q) begin
                    take_redraw = 1'b1;
                    mode_d      = MODE_FULL;
                    idx_d       = 6'd0;
                    state_d     = ST_ISSUE;
                end else if (cell_pend_q) begin
                    mode_d  = MODE_CELL;
                    idx_d   = cell_idx_q;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (plot_done) state_d = (mode_q == MODE_FULL && idx_q != 6'(NUM_CELLS - 1)) ? ST_NEXT : ST_FIN;
            ST_NEXT: begin
                idx_d   = idx_q + 6'd1;
                state_d = ST_ISSUE;
            end
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        fin_full      = state_q == ST_FIN && mode_q == MODE_FULL;
        fin_cell      = state_q == ST_FIN && mode_q == MODE_CELL;
        // A redraw_req arriving as the pending one is taken starts a fresh request
        redraw_pend_d = redraw_req | (redraw_pend_q & ~take_redraw);
        // cell_pend is never set and cleared in one cycle: acceptance needs it low, clearing needs it high
        cell_accept   = cell_req & ~cell_pend_q;
        cell_pend_d   = cell_accept | (cell_pend_q & ~fin_cell);
        cell_idx_d    = cell_accept ? cell_idx : cell_idx_q;
        issue         = state_d == ST_ISSUE;
        plot_start_d  = issue;
        plot_x_d      = issue ? cell_x : plot_x_q;
        plot_y_d      = issue ? cell_y : plot_y_q;
        plot_select_d = issue ? board[{idx_d, 1'b0} +: 2] : plot_select_q;
        busy_d        = state_d != ST_IDLE;
        redraw_done_d = fin_full;
        cell_done_d   = fin_cell;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            mode_q        <= MODE_FULL;
            idx_q         <= 6'd0;
            cell_idx_q    <= 6'd0;
            redraw_pend_q <= 1'b0;
            cell_pend_q   <= 1'b0;
            plot_start_q  <= 1'b0;
            plot_x_q      <= 8'd0;
            plot_y_q      <= 7'd0;
            plot_select_q <= 2'd0;
            busy_q        <= 1'b0;
            redraw_done_q <= 1'b0;
            cell_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            idx_q         <= idx_d;
            cell_idx_q    <= cell_idx_d;
            redraw_pend_q <= redraw_pend_d;
            cell_pend_q   <= cell_pend_d;
            plot_start_q  <= plot_start_d;
            plot_x_q      <= plot_x_d;
            plot_y_q      <= plot_y_d;
            plot_select_q <= plot_select_d;
            busy_q        <= busy_d;
            redraw_done_q <= redraw_done_d;
            cell_done_q   <= cell_done_d;
        end
    end

    assign cell_ready  = ~cell_pend_q;
    assign plot_start  = plot_start_q;
    assign plot_x      = plot_x_q;
    assign plot_y      = plot_y_q;
    assign plot_select = plot_select_q;
    assign busy        = busy_q;
    assign redraw_done = redraw_done_q;
    assign cell_done   = cell_done_q;
endmodule
